// File: rtl/phase_det_pkg.sv
// Shared helpers for the phase detector: sizing of the edge-divider counters.
package phase_det_pkg;

  // Counter width for a 0..n-1 divider; never narrower than one bit.
  function automatic int unsigned div_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phase_det_edge_div.sv
// Synchronizes an asynchronous clock, detects rising edges and divides them by DIV_N.
module phase_det_edge_div
  import phase_det_pkg::*;
#(
  parameter int unsigned DIV_N = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_bypass,
  input  logic i_clr,
  input  logic i_async,
  output logic o_event
);

  localparam int unsigned CntW = div_cnt_w(DIV_N);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV_N - 1);

  logic            sync1_q, sync2_q, prev_q;
  logic            edge_p;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Synchronizer and edge history run regardless of enable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    edge_p  = sync2_q & ~prev_q;
    cnt_d   = cnt_q;
    o_event = i_en & ~i_clr & edge_p & (i_bypass | (cnt_q == CntLast));
    if (!i_en || i_bypass || i_clr) begin
      cnt_d = '0;
    end else if (edge_p) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/phase_det.sv
// Time-interval phase detector: counts i_clk tics from a divided eclk1 edge to a divided eclk2 edge.
module phase_det #(
  parameter int unsigned TIC_BITS = 16,
  parameter int unsigned DIV_N1   = 10,
  parameter int unsigned DIV_N2   = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_eclk2_slow,
  output logic [TIC_BITS-1:0] o_count,
  output logic                o_count_rdy,
  input  logic                i_eclk1,
  input  logic                i_eclk2
);

  logic                start, stop;
  logic                slow_q, mode_chg;
  logic                armed_q;
  logic                rdy_q;
  logic [TIC_BITS-1:0] tic_q, count_q;

  assign mode_chg = slow_q ^ i_eclk2_slow;

  phase_det_edge_div #(
    .DIV_N (DIV_N1)
  ) u_div1 (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (i_en),
    .i_bypass (1'b0),
    .i_clr    (1'b0),
    .i_async  (i_eclk1),
    .o_event  (start)
  );

  phase_det_edge_div #(
    .DIV_N (DIV_N2)
  ) u_div2 (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (i_en),
    .i_bypass (i_eclk2_slow),
    .i_clr    (mode_chg),
    .i_async  (i_eclk2),
    .o_event  (stop)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slow_q  <= 1'b0;
      armed_q <= 1'b0;
      rdy_q   <= 1'b0;
      tic_q   <= '0;
      count_q <= '0;
    end else begin
      slow_q <= i_eclk2_slow;
      rdy_q  <= 1'b0;
      if (!i_en) begin
        armed_q <= 1'b0;
      end else begin
        // tic_q lags the cycle distance by one, so the stop cycle itself is added here.
        if (armed_q && stop) begin
          count_q <= tic_q + TIC_BITS'(1);
          rdy_q   <= 1'b1;
        end
        if (start) begin
          tic_q   <= '0;
          armed_q <= 1'b1;
        end else if (mode_chg || stop) begin
          armed_q <= 1'b0;
        end else if (armed_q) begin
          tic_q <= tic_q + TIC_BITS'(1);
        end
      end
    end
  end

  assign o_count     = count_q;
  assign o_count_rdy = rdy_q;

endmodule

// File: tb/tb_phase_det.sv
// Randomized bench for phase_det with a cycle-indexed interval model of start/stop events.
module tb_phase_det;

  localparam int unsigned TB = 6;
  localparam int unsigned N1 = 4;
  localparam int unsigned N2 = 4;

  logic          clk = 1'b0;
  logic          rst, en, slow, e1, e2;
  logic [TB-1:0] cnt;
  logic          rdy;

  always #2 clk = ~clk;

  phase_det #(
    .TIC_BITS (TB),
    .DIV_N1   (N1),
    .DIV_N2   (N2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_eclk2_slow (slow),
    .o_count      (cnt),
    .o_count_rdy  (rdy),
    .i_eclk1      (e1),
    .i_eclk2      (e2)
  );

  int vecs = 0;
  int errs = 0;

  // Reference model: input level history (as seen by the detector), edge totals, interval start.
  bit            h1_2, h1_1, h1_0, h2_2, h2_1, h2_0;
  int            cyc = 0;
  int            e1n, e2n;
  bit            m_armed, m_slowprev;
  int            m_start;
  logic [TB-1:0] exp_cnt;
  bit            exp_rdy;

  // Square-wave generators.
  bit        g1 = 1'b0, g2 = 1'b0;
  int        g1_left = 0, g2_left = 0;
  bit [15:0] dly = '0;

  task automatic gen(inout bit lvl, inout int left, input int lo, input int hi);
    if (left <= 0) begin
      lvl  = ~lvl;
      left = $urandom_range(hi, lo);
    end
    left--;
  endtask

  // Applies one cycle of inputs, advances the model to the next posedge, waits for the negedge.
  task automatic tick(input bit r, input bit en_v, input bit sl, input bit d1, input bit d2);
    bit p1, p2, mc, st, sp, n1, n2;
    rst = r; en = en_v; slow = sl; e1 = d1; e2 = d2;
    n1 = d1; n2 = d2;
    if (r) begin
      h1_0 = 0; n1 = 0; h2_0 = 0; n2 = 0;
      e1n = 0; e2n = 0; m_armed = 0; m_slowprev = 0;
      exp_cnt = '0; exp_rdy = 0;
    end else begin
      p1 = h1_1 & ~h1_2;
      p2 = h2_1 & ~h2_2;
      mc = (sl != m_slowprev);
      m_slowprev = sl;
      exp_rdy = 0;
      if (!en_v) begin
        e1n = 0; e2n = 0; m_armed = 0;
      end else begin
        st = 0; sp = 0;
        if (p1) begin
          e1n++;
          st = (e1n % N1) == 0;
        end
        if (mc) e2n = 0;
        else if (sl) begin
          e2n = 0;
          sp  = p2;
        end else if (p2) begin
          e2n++;
          sp = (e2n % N2) == 0;
        end
        if (m_armed && sp) begin
          exp_cnt = TB'(cyc - m_start);
          exp_rdy = 1;
        end
        if (st) begin
          m_armed = 1;
          m_start = cyc;
        end else if (mc || sp) m_armed = 0;
      end
    end
    h1_2 = h1_1; h1_1 = h1_0; h1_0 = n1;
    h2_2 = h2_1; h2_1 = h2_0; h2_0 = n2;
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, 0, 0, 0);
      vecs++;
      if ({rdy, cnt} !== {exp_rdy, exp_cnt}) begin
        errs++;
        $display("FAIL reset cyc=%0d got rdy=%b cnt=%0d want rdy=%b cnt=%0d",
                 cyc, rdy, cnt, exp_rdy, exp_cnt);
      end
    end
  endtask

  // Same waveform on both inputs: every interval is N1 eclk periods.
  task automatic test_coincident(input int hp, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      gen(g1, g1_left, hp, hp);
      tick(0, 1, 0, g1, g1);
      vecs++;
      if ({rdy, cnt} !== {exp_rdy, exp_cnt}) begin
        errs++;
        $display("FAIL coincident cyc=%0d got rdy=%b cnt=%0d want rdy=%b cnt=%0d",
                 cyc, rdy, cnt, exp_rdy, exp_cnt);
      end
    end
  endtask

  // eclk2 is a delayed copy of eclk1; long periods exercise counter wrap.
  task automatic test_offset(input int hp, input int k, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      gen(g1, g1_left, hp, hp);
      dly = {dly[14:0], g1};
      tick(0, 1, 0, g1, dly[k]);
      vecs++;
      if ({rdy, cnt} !== {exp_rdy, exp_cnt}) begin
        errs++;
        $display("FAIL offset hp=%0d k=%0d cyc=%0d got rdy=%b cnt=%0d want rdy=%b cnt=%0d",
                 hp, k, cyc, rdy, cnt, exp_rdy, exp_cnt);
      end
    end
  endtask

  task automatic test_random(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      gen(g1, g1_left, 2, 6);
      gen(g2, g2_left, 2, 7);
      tick(0, 1, 0, g1, g2);
      vecs++;
      if ({rdy, cnt} !== {exp_rdy, exp_cnt}) begin
        errs++;
        $display("FAIL random cyc=%0d got rdy=%b cnt=%0d want rdy=%b cnt=%0d",
                 cyc, rdy, cnt, exp_rdy, exp_cnt);
      end
    end
  endtask

  task automatic test_enable(input int ncyc);
    bit en_v = 1;
    for (int i = 0; i < ncyc; i++) begin
      if ($urandom_range(39, 0) == 0) en_v = ~en_v;
      gen(g1, g1_left, 2, 4);
      gen(g2, g2_left, 2, 4);
      tick(0, en_v, 0, g1, g2);
      vecs++;
      if ({rdy, cnt} !== {exp_rdy, exp_cnt}) begin
        errs++;
        $display("FAIL enable en=%b cyc=%0d got rdy=%b cnt=%0d want rdy=%b cnt=%0d",
                 en_v, cyc, rdy, cnt, exp_rdy, exp_cnt);
      end
    end
  endtask

  // Undivided low-rate eclk2 pulses, with occasional mode flips mid-interval.
  task automatic test_slow(input int ncyc);
    bit sl = 1;
    int next = 20;
    int hi = 0;
    for (int i = 0; i < ncyc; i++) begin
      if ($urandom_range(99, 0) == 0) sl = ~sl;
      gen(g1, g1_left, 2, 2);
      if (next == 0) begin
        hi   = 2;
        next = $urandom_range(60, 30);
      end
      next--;
      tick(0, 1, sl, g1, hi > 0);
      if (hi > 0) hi--;
      vecs++;
      if ({rdy, cnt} !== {exp_rdy, exp_cnt}) begin
        errs++;
        $display("FAIL slow sl=%b cyc=%0d got rdy=%b cnt=%0d want rdy=%b cnt=%0d",
                 sl, cyc, rdy, cnt, exp_rdy, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid(input int ncyc);
    bit r;
    for (int i = 0; i < ncyc; i++) begin
      r = ($urandom_range(59, 0) == 0);
      gen(g1, g1_left, 2, 3);
      dly = {dly[14:0], g1};
      tick(r, 1, 0, g1, dly[5]);
      vecs++;
      if ({rdy, cnt} !== {exp_rdy, exp_cnt}) begin
        errs++;
        $display("FAIL reset_mid rst=%b cyc=%0d got rdy=%b cnt=%0d want rdy=%b cnt=%0d",
                 r, cyc, rdy, cnt, exp_rdy, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_coincident(2, 300);
    test_offset(2, 2, 300);
    test_offset(5, 3, 600);
    test_offset(10, 7, 1200);
    test_random(1500);
    test_enable(1500);
    test_slow(2000);
    test_reset_mid(1500);
    test_reset();
    test_random(500);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
